// File: rtl/otter_pkg.sv
// Shared constants for the OTTER fetch stage: next-PC select codes, NOP,
// fetch FSM state encoding and error-flag bit positions.
package otter_pkg;

  localparam logic [2:0] PC_SRC_PLUS4  = 3'd0;
  localparam logic [2:0] PC_SRC_JALR   = 3'd1;
  localparam logic [2:0] PC_SRC_BRANCH = 3'd2;
  localparam logic [2:0] PC_SRC_JAL    = 3'd3;
  localparam logic [2:0] PC_SRC_MTVEC  = 3'd4;
  localparam logic [2:0] PC_SRC_MEPC   = 3'd5;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  localparam int ERR_TIMEOUT  = 0;
  localparam int ERR_MISALIGN = 1;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/otter_pc_mux.sv
// Combinational next-PC selector with the PC+4 adder; unused select codes
// fall back to sequential flow.
module otter_pc_mux
  import otter_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [2:0]  pc_source,
  input  logic [31:0] jalr,
  input  logic [31:0] branch,
  input  logic [31:0] jal,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    next_pc = pc_plus4;
    case (pc_source)
      PC_SRC_JALR:   next_pc = jalr;
      PC_SRC_BRANCH: next_pc = branch;
      PC_SRC_JAL:    next_pc = jal;
      PC_SRC_MTVEC:  next_pc = mtvec;
      PC_SRC_MEPC:   next_pc = mepc;
      default:       next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/otter_fetch.sv
// OTTER instruction-fetch stage: PC register, two-state fetch FSM with a
// bounded wait on imem_valid, and the instruction register.
module otter_fetch
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic        pc_write,
  input  logic [2:0]  pc_source,
  input  logic [31:0] jalr,
  input  logic [31:0] branch,
  input  logic [31:0] jal,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        imem_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        fetch_done,
  output logic        busy,
  output logic [1:0]  err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic             ir_valid_q, ir_valid_d;
  logic             fetch_done_q, fetch_done_d;
  logic [1:0]       err_q, err_d;
  logic [31:0]      next_pc;

  otter_pc_mux u_pc_mux (
    .pc        (pc_q),
    .pc_source (pc_source),
    .jalr      (jalr),
    .branch    (branch),
    .jal       (jal),
    .mtvec     (mtvec),
    .mepc      (mepc),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    ir_valid_d   = ir_valid_q;
    fetch_done_d = 1'b0;
    err_d        = err_q;

    if (state_q == ST_IDLE) begin
      if (pc_write) begin
        if (is_word_aligned(next_pc)) begin
          pc_d       = next_pc;
          ir_valid_d = 1'b0;
        end else begin
          err_d[ERR_MISALIGN] = 1'b1;
        end
      end
      // A simultaneous pc_write lands first, so the request uses the new PC.
      if (fetch_start) begin
        state_d    = ST_REQ;
        ir_valid_d = 1'b0;
        cnt_d      = CNT_W'(TIMEOUT - 1);
      end
    end else begin
      if (imem_valid) begin
        ir_d         = imem_data;
        ir_valid_d   = 1'b1;
        fetch_done_d = 1'b1;
        state_d      = ST_IDLE;
      end else if (cnt_q == '0) begin
        err_d[ERR_TIMEOUT] = 1'b1;
        state_d            = ST_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pc_q         <= RESET_PC;
      ir_q         <= NOP_INSTR;
      ir_valid_q   <= 1'b0;
      fetch_done_q <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      fetch_done_q <= fetch_done_d;
      err_q        <= err_d;
    end
  end

  assign imem_req   = (state_q == ST_REQ);
  assign busy       = imem_req;
  assign imem_addr  = imem_req ? pc_q : 32'h0;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign ir_valid   = ir_valid_q;
  assign fetch_done = fetch_done_q;
  assign err        = err_q;

endmodule
